// File: rtl/mioc_flop_pkg.sv
// Shared definitions for the MIOC sticky event flag bank: detect modes and
// the ID-width helper.
package mioc_flop_pkg;

  localparam logic [1:0] MODE_OFF  = 2'b00;
  localparam logic [1:0] MODE_RISE = 2'b01;
  localparam logic [1:0] MODE_FALL = 2'b10;
  localparam logic [1:0] MODE_BOTH = 2'b11;

  typedef logic [1:0] mode_t;

  // A single channel still needs a 1-bit ID port.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mioc_flag_cell.sv
// One flag channel: event synchroniser, edge history, mode-qualified edge
// strobe and the sticky flag/overflow pair.
module mioc_flag_cell
  import mioc_flop_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter logic INIT_LEVEL  = 1'b0
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  evt,
  input  mode_t mode,
  input  logic  force_set,
  input  logic  ack,
  output logic  q,
  output logic  ovf
);

  logic [SYNC_STAGES-1:0] sync_p;
  logic                   hist_p;
  logic                   s;
  logic                   rise;
  logic                   fall;
  logic                   strobe;
  logic                   set;

  assign s    = sync_p[SYNC_STAGES-1];
  assign rise = s & ~hist_p;
  assign fall = ~s & hist_p;

  always_comb begin
    strobe = 1'b0;
    unique case (mode)
      MODE_RISE: strobe = rise;
      MODE_FALL: strobe = fall;
      MODE_BOTH: strobe = rise | fall;
      default:   strobe = 1'b0;
    endcase
  end

  assign set = strobe | force_set;

  // History is reset to the same level as the synchroniser, so leaving
  // reset cannot look like an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p <= {SYNC_STAGES{INIT_LEVEL}};
      hist_p <= INIT_LEVEL;
      q      <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      sync_p <= {sync_p[SYNC_STAGES-2:0], evt};
      hist_p <= s;
      if (set) begin
        q <= 1'b1;
        if (ack)    ovf <= 1'b0;
        else if (q) ovf <= 1'b1;
      end else if (ack) begin
        q   <= 1'b0;
        ovf <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/mioc_flag_bank.sv
// Bank of CHANNELS sticky event flags with aggregated interrupt and
// lowest-index channel ID.
module mioc_flag_bank
  import mioc_flop_pkg::*;
#(
  parameter int   CHANNELS    = 4,
  parameter int   SYNC_STAGES = 2,
  parameter logic INIT_LEVEL  = 1'b0
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [CHANNELS-1:0]               evt_i,
  input  logic [2*CHANNELS-1:0]             mode_i,
  input  logic [CHANNELS-1:0]               force_set_i,
  input  logic [CHANNELS-1:0]               ack_i,
  output logic [CHANNELS-1:0]               q_o,
  output logic [CHANNELS-1:0]               qbar_o,
  output logic [CHANNELS-1:0]               ovf_o,
  output logic                              irq_o,
  output logic [clog2_min1(CHANNELS)-1:0]   irq_id_o
);

  localparam int ID_W = clog2_min1(CHANNELS);

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    mioc_flag_cell #(
      .SYNC_STAGES (SYNC_STAGES),
      .INIT_LEVEL  (INIT_LEVEL)
    ) u_cell (
      .clk       (clk),
      .rst_n     (rst_n),
      .evt       (evt_i[k]),
      .mode      (mode_t'(mode_i[2*k+1:2*k])),
      .force_set (force_set_i[k]),
      .ack       (ack_i[k]),
      .q         (q_o[k]),
      .ovf       (ovf_o[k])
    );
  end

  assign qbar_o = ~q_o;
  assign irq_o  = |q_o;

  // Scan from the top down so the lowest set index is the last to write.
  always_comb begin
    irq_id_o = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (q_o[i]) irq_id_o = ID_W'(i);
    end
  end

endmodule

// File: tb/tb_mioc_flag_bank.sv
// Directed bench for mioc_flag_bank (4 channels, 2-stage synchroniser).
module tb_mioc_flag_bank;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] evt_i;
  logic [7:0] mode_i;
  logic [3:0] force_set_i;
  logic [3:0] ack_i;
  logic [3:0] q_o;
  logic [3:0] qbar_o;
  logic [3:0] ovf_o;
  logic       irq_o;
  logic [1:0] irq_id_o;

  int passed = 0;
  int total  = 0;

  mioc_flag_bank #(
    .CHANNELS    (4),
    .SYNC_STAGES (2),
    .INIT_LEVEL  (1'b0)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .evt_i       (evt_i),
    .mode_i      (mode_i),
    .force_set_i (force_set_i),
    .ack_i       (ack_i),
    .q_o         (q_o),
    .qbar_o      (qbar_o),
    .ovf_o       (ovf_o),
    .irq_o       (irq_o),
    .irq_id_o    (irq_id_o)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  initial begin
    rst_n = 1'b0; evt_i = '0; mode_i = '0; force_set_i = '0; ack_i = '0;
    #12;
    chk("por_q", q_o, 4'h0);
    chk("por_qbar", qbar_o, 4'hF);
    rst_n = 1'b1;
    tick();

    // Mid-run asynchronous reset with q=1010
    force_set_i = 4'b1010;
    tick();
    force_set_i = '0;
    chk("pre_rst_q", q_o, 4'b1010);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_q", q_o, 4'h0);
    chk("rst_qbar", qbar_o, 4'hF);
    chk("rst_ovf", ovf_o, 4'h0);
    chk("rst_irq", irq_o, 1'b0);
    chk("rst_id", irq_id_o, 2'd0);
    #1 rst_n = 1'b1;
    mode_i = 8'b11_11_11_11;
    tick(4);
    chk("post_rst_idle", q_o, 4'h0);

    // Rising-edge latency on ch0
    mode_i = 8'b00_00_00_01;
    evt_i[0] = 1'b1;
    tick();
    chk("rise_n", q_o[0], 1'b0);
    tick();
    chk("rise_n1", q_o[0], 1'b0);
    tick();
    chk("rise_n2", q_o[0], 1'b1);
    chk("rise_irq", irq_o, 1'b1);
    chk("rise_id", irq_id_o, 2'd0);
    evt_i[0] = 1'b0;
    tick(4);
    chk("rise_fall_q", q_o, 4'b0001);
    chk("rise_fall_ovf", ovf_o, 4'b0000);
    ack_i = 4'b0001;
    tick();
    ack_i = '0;
    chk("rise_ack", q_o, 4'h0);

    // ch1 falling, ch2 both edges
    mode_i = 8'b00_11_10_00;
    evt_i[2:1] = 2'b11;
    tick(5);
    chk("pulse_high_q", q_o, 4'b0100);
    chk("pulse_high_ovf", ovf_o, 4'b0000);
    evt_i[2:1] = 2'b00;
    tick(4);
    chk("pulse_low_q", q_o, 4'b0110);
    chk("pulse_low_ovf", ovf_o, 4'b0100);
    ack_i = 4'b0110;
    tick();
    ack_i = '0;
    chk("pulse_ack_q", q_o, 4'h0);
    chk("pulse_ack_ovf", ovf_o, 4'h0);

    // Same-cycle set and ack on ch3
    force_set_i = 4'b1000;
    tick(2);
    chk("ovf3_q", q_o, 4'b1000);
    chk("ovf3_ovf", ovf_o, 4'b1000);
    ack_i = 4'b1000;
    tick();
    chk("setack_q", q_o, 4'b1000);
    chk("setack_ovf", ovf_o, 4'b0000);
    force_set_i = '0;
    tick();
    ack_i = '0;
    chk("ack3_q", q_o[3], 1'b0);
    chk("ack3_qbar", qbar_o[3], 1'b1);

    // Priority encoder
    force_set_i = 4'b1010;
    tick();
    force_set_i = '0;
    chk("prio_irq", irq_o, 1'b1);
    chk("prio_id_1", irq_id_o, 2'd1);
    ack_i = 4'b0010;
    tick();
    chk("prio_id_3", irq_id_o, 2'd3);
    ack_i = 4'b1000;
    tick();
    ack_i = '0;
    chk("prio_irq_off", irq_o, 1'b0);
    chk("prio_id_0", irq_id_o, 2'd0);

    // Mode handling: off holds the flag, mode changes make no event
    mode_i = 8'b00_00_00_01;
    force_set_i = 4'b0001;
    tick();
    force_set_i = '0;
    mode_i = 8'b00_00_00_00;
    evt_i[0] = 1'b1;
    tick(3);
    evt_i[0] = 1'b0;
    tick(3);
    chk("off_hold_q", q_o, 4'b0001);
    chk("off_hold_ovf", ovf_o, 4'b0000);
    ack_i = 4'b0001;
    tick();
    ack_i = '0;
    evt_i[0] = 1'b1;
    tick(4);
    mode_i = 8'b00_00_00_01;
    tick(2);
    mode_i = 8'b00_00_00_10;
    tick(3);
    chk("modeswitch_q", q_o, 4'h0);
    evt_i[0] = 1'b0;
    tick(3);
    chk("fall_after_switch", q_o, 4'b0001);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
